// File: rtl/song_sequencer_if.sv
// Control, status and song-ROM signals shared between a player front end and the sequencer.
// The master side drives the controls and returns ROM words; the slave is the sequencer.
interface song_sequencer_if;
  logic        start;
  logic        stop;
  logic        pause;
  logic        loop;
  logic [1:0]  tempo_sel;
  logic [5:0]  rom_addr;
  logic [10:0] rom_data;
  logic [6:0]  note;
  logic        busy;
  logic        song_done;

  modport master (
    output start, stop, pause, loop, tempo_sel, rom_data,
    input  rom_addr, note, busy, song_done
  );

  modport slave (
    input  start, stop, pause, loop, tempo_sel, rom_data,
    output rom_addr, note, busy, song_done
  );
endinterface

// File: rtl/song_sequencer.sv
// Steps through a 64-entry song ROM, playing each note for beats*beat_len cycles
// followed by a fixed silent gap, with pause, stop and loop controls.
module song_sequencer #(
  parameter int unsigned BEAT_CYCLES = 25000000,
  parameter int unsigned GAP_CYCLES  = 2500000
) (
  input  logic              clk,
  input  logic              rst,
  song_sequencer_if.slave   bus
);

  localparam int unsigned PLAY_MAX = 15 * BEAT_CYCLES;
  localparam int unsigned CNT_MAX  = (PLAY_MAX > GAP_CYCLES) ? PLAY_MAX : GAP_CYCLES;
  localparam int unsigned CW       = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    PLAY,
    GAP
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [6:0]    note_lat;

  logic [3:0]    beats;
  logic [6:0]    idx;
  logic [6:0]    clean_note;
  logic [CW-1:0] beat_len;
  logic [CW-1:0] play_len;
  logic          end_restart;

  always_comb begin
    beats       = bus.rom_data[3:0];
    idx         = bus.rom_data[10:4];
    clean_note  = (idx > 7'd21) ? 7'd0 : idx;
    beat_len    = CW'(BEAT_CYCLES) >> bus.tempo_sel;
    play_len    = CW'(beats) * beat_len;
    // An end marker at address 0 is an empty song; never loop on it.
    end_restart = bus.loop && (bus.rom_addr != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      note_lat      <= '0;
      bus.note      <= '0;
      bus.rom_addr  <= '0;
      bus.busy      <= 1'b0;
      bus.song_done <= 1'b0;
    end else begin
      bus.song_done <= 1'b0;
      if (bus.stop) begin
        state        <= IDLE;
        cnt          <= '0;
        bus.note     <= '0;
        bus.rom_addr <= '0;
        bus.busy     <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            bus.note     <= '0;
            bus.rom_addr <= '0;
            if (bus.start) begin
              state    <= FETCH;
              bus.busy <= 1'b1;
            end
          end

          FETCH: state <= DECODE;

          DECODE: begin
            if (beats == 4'd0) begin
              bus.rom_addr <= '0;
              if (end_restart) begin
                state <= FETCH;
              end else begin
                state         <= IDLE;
                bus.busy      <= 1'b0;
                bus.song_done <= 1'b1;
              end
            end else begin
              note_lat <= clean_note;
              bus.note <= clean_note;
              cnt      <= play_len;
              state    <= PLAY;
            end
          end

          PLAY: begin
            if (bus.pause) begin
              bus.note <= '0;
            end else if (cnt == CW'(1)) begin
              cnt      <= CW'(GAP_CYCLES);
              bus.note <= '0;
              state    <= GAP;
            end else begin
              cnt      <= cnt - CW'(1);
              bus.note <= note_lat;
            end
          end

          GAP: begin
            if (!bus.pause) begin
              if (cnt == CW'(1)) begin
                cnt <= '0;
                // Running off the last address behaves like reading an end marker.
                if (bus.rom_addr == '1) begin
                  bus.rom_addr <= '0;
                  if (end_restart) begin
                    state <= FETCH;
                  end else begin
                    state         <= IDLE;
                    bus.busy      <= 1'b0;
                    bus.song_done <= 1'b1;
                  end
                end else begin
                  bus.rom_addr <= bus.rom_addr + 6'd1;
                  state        <= FETCH;
                end
              end else begin
                cnt <= cnt - CW'(1);
              end
            end
          end

          default: begin
            state    <= IDLE;
            bus.busy <= 1'b0;
            bus.note <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_song_sequencer.sv
// Scoreboard bench: each scenario queues the expected per-cycle note/busy/done/addr
// trace, and a negedge monitor pops and compares it against the sequencer outputs.
module tb_song_sequencer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  song_sequencer_if bus ();

  song_sequencer #(
    .BEAT_CYCLES(10),
    .GAP_CYCLES (2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [10:0] rom [64];
  always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

  typedef struct packed {
    logic [6:0] note;
    logic       busy;
    logic       done;
    logic [5:0] addr;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   total = 0;
  int   bad   = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      cur = sb.pop_front();
      check_eq("note",      int'(bus.note),      int'(cur.note));
      check_eq("busy",      int'(bus.busy),      int'(cur.busy));
      check_eq("song_done", int'(bus.song_done), int'(cur.done));
      check_eq("rom_addr",  int'(bus.rom_addr),  int'(cur.addr));
    end
  end

  function automatic logic [10:0] mk(input int n, input int b);
    return {7'(n), 4'(b)};
  endfunction

  task automatic push(input int n, input int note, input int busy, input int done, input int addr);
    exp_t e;
    e.note = 7'(note);
    e.busy = 1'(busy);
    e.done = 1'(done);
    e.addr = 6'(addr);
    for (int i = 0; i < n; i++) sb.push_back(e);
  endtask

  task automatic push_idle(input int n);
    push(n, 0, 0, 0, 0);
  endtask

  task automatic push_fd(input int addr);
    push(2, 0, 1, 0, addr);
  endtask

  task automatic push_done();
    push(1, 0, 0, 1, 0);
    push_idle(3);
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 64; i++) rom[i] = '0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 2000 && sb.size() != 0; i++) @(negedge clk);
    check_eq("drain_timeout", sb.size(), 0);
    sb.delete();
    @(posedge clk); #1;
  endtask

  task automatic push_basic_tail();
    push(2, 0, 1, 0, 0);
    push_fd(1);
    push(10, 10, 1, 0, 1);
    push(2, 0, 1, 0, 1);
    push_fd(2);
    push_done();
  endtask

  initial begin
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.stop      = 1'b0;
    bus.pause     = 1'b0;
    bus.loop      = 1'b0;
    bus.tempo_sel = 2'd0;
    clear_rom();

    // Reset and quiet idle
    push_idle(22);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    drain();

    // Basic two-note song
    rom[0] = mk(8, 2); rom[1] = mk(10, 1); rom[2] = mk(0, 0);
    push_idle(1); push_fd(0); push(20, 8, 1, 0, 0); push_basic_tail();
    pulse_start();
    drain();

    // Pause for 7 cycles during note 8
    push_idle(1); push_fd(0); push(5, 8, 1, 0, 0); push(7, 0, 1, 0, 0);
    push(15, 8, 1, 0, 0); push_basic_tail();
    pulse_start();
    repeat (6) @(posedge clk);
    #1 bus.pause = 1'b1;
    repeat (7) @(posedge clk);
    #1 bus.pause = 1'b0;
    drain();

    // Reset mid-note with start held high in the same cycle
    push_idle(1); push_fd(0); push(3, 8, 1, 0, 0); push_idle(6);
    pulse_start();
    repeat (4) @(posedge clk);
    #1 rst = 1'b1; bus.start = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0; bus.start = 1'b0;
    drain();

    // Looping song, then stop+start in cycle 5 of the repeated note 8
    bus.loop = 1'b1;
    push_idle(1); push_fd(0); push(20, 8, 1, 0, 0); push(2, 0, 1, 0, 0);
    push_fd(1); push(10, 10, 1, 0, 1); push(2, 0, 1, 0, 1);
    push_fd(2); push_fd(0); push(5, 8, 1, 0, 0); push_idle(10);
    pulse_start();
    repeat (46) @(posedge clk);
    #1 bus.stop = 1'b1; bus.start = 1'b1;
    @(posedge clk);
    #1 bus.stop = 1'b0; bus.start = 1'b0;
    drain();

    // Empty song with loop set must still terminate
    clear_rom();
    push_idle(1); push_fd(0); push_done();
    pulse_start();
    drain();
    bus.loop = 1'b0;

    // Out-of-range note is a rest; a second start while busy is ignored
    rom[0] = mk(25, 1); rom[1] = mk(0, 0);
    push_idle(1); push_fd(0); push(10, 0, 1, 0, 0); push(2, 0, 1, 0, 0);
    push_fd(1); push_done();
    pulse_start();
    repeat (3) @(posedge clk);
    #1 bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    drain();

    // Double tempo halves the beat
    bus.tempo_sel = 2'd1;
    rom[0] = mk(8, 2); rom[1] = mk(0, 0);
    push_idle(1); push_fd(0); push(10, 8, 1, 0, 0); push(2, 0, 1, 0, 0);
    push_fd(1); push_done();
    pulse_start();
    drain();

    // Full 64-entry song with no end marker finishes after address 63
    bus.tempo_sel = 2'd3;
    for (int a = 0; a < 64; a++) rom[a] = mk(a % 21 + 1, 1);
    push_idle(1);
    for (int a = 0; a < 64; a++) begin
      push_fd(a);
      push(1, a % 21 + 1, 1, 0, a);
      push(2, 0, 1, 0, a);
    end
    push_done();
    pulse_start();
    drain();
    bus.tempo_sel = 2'd0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
